// File: rtl/csc_pkg.sv
// Shared constants for the RGB -> YCbCr colour-space converter: mode encoding,
// pipeline latency and the BT.601 / BT.709 coefficient derivation.
package csc_pkg;

  localparam int unsigned LATENCY = 4;

  typedef enum logic {
    MODE_601 = 1'b0,
    MODE_709 = 1'b1
  } mode_t;

  localparam real KR_601 = 0.299;
  localparam real KB_601 = 0.114;
  localparam real KR_709 = 0.2126;
  localparam real KB_709 = 0.0722;

  // Real-valued matrix entry; idx = 3*row + col, rows {Y,Cb,Cr}, cols {R,G,B}
  function automatic real coef_real(mode_t m, int unsigned idx);
    real kr;
    real kb;
    real kg;
    real r;
    kr = (m == MODE_709) ? KR_709 : KR_601;
    kb = (m == MODE_709) ? KB_709 : KB_601;
    kg = 1.0 - kr - kb;
    case (idx)
      0:       r = kr;
      1:       r = kg;
      2:       r = kb;
      3:       r = -kr / (2.0 - 2.0 * kb);
      4:       r = -kg / (2.0 - 2.0 * kb);
      5:       r = 0.5;
      6:       r = 0.5;
      7:       r = -kg / (2.0 - 2.0 * kr);
      8:       r = -kb / (2.0 - 2.0 * kr);
      default: r = 0.0;
    endcase
    return r;
  endfunction

  // Entry rounded to nearest at 'frac' fractional bits (symmetric about zero)
  function automatic int coef_q(mode_t m, int unsigned idx, int unsigned frac);
    real s;
    s = coef_real(m, idx) * real'(1 << frac);
    return (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(0.5 - s);
  endfunction

endpackage

// File: rtl/csc_if.sv
// Video bus for the colour-space converter: RGB pixel and timing in,
// YCbCr pixel and delayed timing out.
interface csc_if #(
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned OUT_W = DATA_W + 1;

  logic [3*DATA_W-1:0] pixel_in;
  logic                de_in;
  logic                hsync_in;
  logic                vsync_in;
  logic                mode_in;
  logic [3*OUT_W-1:0]  pixel_out;
  logic                de_out;
  logic                hsync_out;
  logic                vsync_out;
  logic                mode_active;

  modport master (
    output pixel_in, de_in, hsync_in, vsync_in, mode_in,
    input  pixel_out, de_out, hsync_out, vsync_out, mode_active
  );

  modport slave (
    input  pixel_in, de_in, hsync_in, vsync_in, mode_in,
    output pixel_out, de_out, hsync_out, vsync_out, mode_active
  );
endinterface

// File: rtl/csc_delay.sv
// Parametrised shift register with async active-high clear; q is d delayed
// by DEPTH clocks.
module csc_delay #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] taps [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) taps[i] <= '0;
    end else begin
      taps[0] <= d;
      for (int i = 1; i < int'(DEPTH); i++) taps[i] <= taps[i-1];
    end
  end

  assign q = taps[DEPTH-1];
endmodule

// File: rtl/csc_pipeline.sv
// 4-stage full-range RGB -> YCbCr converter. BT.601 always; BT.709 and the
// vsync-latched mode select are built only when CSC_BT709_EN is defined.
module csc_pipeline
  import csc_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned COEF_FRAC = 12
) (
  input logic clk,
  input logic rst,
  csc_if.slave bus
);
  localparam int unsigned OUT_W = DATA_W + 1;
  localparam int unsigned PW    = DATA_W + COEF_FRAC + 4;
  localparam int unsigned CW    = COEF_FRAC + 2;

  localparam logic signed [PW-1:0] RND   = PW'(1 << (COEF_FRAC - 1));
  localparam logic signed [PW-1:0] Y_MIN = '0;
  localparam logic signed [PW-1:0] Y_MAX = PW'((1 << DATA_W) - 1);
  localparam logic signed [PW-1:0] C_MIN = PW'(-(1 << (DATA_W - 1)));
  localparam logic signed [PW-1:0] C_MAX = PW'((1 << (DATA_W - 1)) - 1);

  logic [3*DATA_W-1:0]  pix_s1;
  logic signed [PW-1:0] prod_s2 [9];
  logic signed [PW-1:0] sum_s3  [3];
  logic [2:0]           sync_s3;

  // Drop fraction (floor after the half-LSB bias) and clamp to component range
  function automatic logic [OUT_W-1:0] sat(input logic signed [PW-1:0] v,
                                           input logic is_y);
    logic signed [PW-1:0] s;
    logic signed [PW-1:0] lo;
    logic signed [PW-1:0] hi;
    s  = v >>> COEF_FRAC;
    lo = is_y ? Y_MIN : C_MIN;
    hi = is_y ? Y_MAX : C_MAX;
    if (s < lo)      s = lo;
    else if (s > hi) s = hi;
    return s[OUT_W-1:0];
  endfunction

`ifdef CSC_BT709_EN
  logic vsync_q;
  logic mode_q;
  logic mode_s1;

  // Mode only changes on a vsync rising edge; the edge-cycle pixel sees the old one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q <= 1'b0;
      mode_q  <= 1'(MODE_601);
    end else begin
      vsync_q <= bus.vsync_in;
      if (bus.vsync_in && !vsync_q) mode_q <= bus.mode_in;
    end
  end

  assign bus.mode_active = mode_q;

  csc_delay #(.WIDTH(1), .DEPTH(1)) u_mode (
    .clk (clk),
    .rst (rst),
    .d   (mode_q),
    .q   (mode_s1)
  );
`else
  logic unused_mode;
  assign unused_mode     = bus.mode_in;
  assign bus.mode_active = 1'b0;
`endif

  // Stage 1: input register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pix_s1 <= '0;
    else     pix_s1 <= bus.pixel_in;
  end

  // Stage 2: nine coefficient multiplies, coefficient set follows the pixel
  for (genvar i = 0; i < 9; i++) begin : g_mul
    localparam logic signed [CW-1:0] K601 = CW'(coef_q(MODE_601, i, COEF_FRAC));
    logic signed [CW-1:0] k;
    logic [DATA_W-1:0]    comp;
`ifdef CSC_BT709_EN
    localparam logic signed [CW-1:0] K709 = CW'(coef_q(MODE_709, i, COEF_FRAC));
    assign k = mode_s1 ? K709 : K601;
`else
    assign k = K601;
`endif
    assign comp = pix_s1[(2 - i % 3) * DATA_W +: DATA_W];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) prod_s2[i] <= '0;
      else     prod_s2[i] <= PW'(signed'({1'b0, comp})) * PW'(k);
    end
  end

  // Stage 3: row sums with the round-half-up bias folded in
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < 3; j++) sum_s3[j] <= '0;
    end else begin
      for (int j = 0; j < 3; j++)
        sum_s3[j] <= prod_s2[3*j] + prod_s2[3*j+1] + prod_s2[3*j+2] + RND;
    end
  end

  csc_delay #(.WIDTH(3), .DEPTH(LATENCY - 1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({bus.de_in, bus.hsync_in, bus.vsync_in}),
    .q   (sync_s3)
  );

  // Stage 4: saturate, blank outside active video, register outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.pixel_out <= '0;
      bus.de_out    <= 1'b0;
      bus.hsync_out <= 1'b0;
      bus.vsync_out <= 1'b0;
    end else begin
      {bus.de_out, bus.hsync_out, bus.vsync_out} <= sync_s3;
      bus.pixel_out <= sync_s3[2] ? {sat(sum_s3[0], 1'b1),
                                     sat(sum_s3[1], 1'b0),
                                     sat(sum_s3[2], 1'b0)} : '0;
    end
  end
endmodule
